// File: rtl/memory_stage_if.sv
// Signal bundle between the execute/control side of the Y86-64 pipeline and the memory stage.
// The memory stage sits on the slave side; the upstream stages and the control logic sit on the master side.
interface memory_stage_if;
    logic [3:0]  e_stat;
    logic [3:0]  e_icode;
    logic        e_cnd;
    logic [63:0] e_valE;
    logic [63:0] e_valA;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;
    logic        M_stall;
    logic        M_bubble;
    logic        W_stall;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valE;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [63:0] m_valM;
    logic [3:0]  m_stat;
    logic [3:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;

    modport slave (
        input  e_stat, e_icode, e_cnd, e_valE, e_valA, e_dstE, e_dstM,
        input  M_stall, M_bubble, W_stall,
        output M_icode, M_cnd, M_valE, M_dstE, M_dstM, m_valM, m_stat,
        output W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
    );

    modport master (
        output e_stat, e_icode, e_cnd, e_valE, e_valA, e_dstE, e_dstM,
        output M_stall, M_bubble, W_stall,
        input  M_icode, M_cnd, M_valE, M_dstE, M_dstM, m_valM, m_stat,
        input  W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
    );
endinterface

// File: rtl/memory_stage.sv
// Y86-64 memory stage: E->M register, byte-addressed little-endian data memory with 8-byte
// accesses, and the M->W register. m_valM/m_stat are combinational for forwarding.
module memory_stage #(
    parameter int DMEM_BYTES = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    memory_stage_if.slave bus
);
    localparam int          AW       = $clog2(DMEM_BYTES);
    localparam logic [63:0] MAX_ADDR = 64'(DMEM_BYTES - 8);
    localparam logic [3:0]  STAT_AOK = 4'd1;
    localparam logic [3:0]  STAT_ADR = 4'd3;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } m_reg_t;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } w_reg_t;

    localparam m_reg_t M_BUBBLE = '{stat: 4'd1, icode: 4'h1, cnd: 1'b0, valE: 64'd0,
                                    valA: 64'd0, dstE: 4'hF, dstM: 4'hF};
    localparam w_reg_t W_BUBBLE = '{stat: 4'd1, icode: 4'h1, valE: 64'd0, valM: 64'd0,
                                    dstE: 4'hF, dstM: 4'hF};

    m_reg_t          m_r;
    w_reg_t          w_r;
    logic [7:0]      dmem_r [DMEM_BYTES];

    logic            rd_s;
    logic            wr_s;
    logic [63:0]     addr_s;
    logic            addr_ok_s;
    logic [AW-1:0]   base_s;
    logic [63:0]     rdata_s;
    logic [3:0]      m_stat_s;
    logic [63:0]     m_valm_s;
    logic            we_s;

    // E->M pipeline register: bubble has priority over stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r <= M_BUBBLE;
        end else if (bus.M_bubble) begin
            m_r <= M_BUBBLE;
        end else if (!bus.M_stall) begin
            m_r <= '{stat: bus.e_stat, icode: bus.e_icode, cnd: bus.e_cnd, valE: bus.e_valE,
                     valA: bus.e_valA, dstE: bus.e_dstE, dstM: bus.e_dstM};
        end else begin
            m_r <= m_r;
        end
    end

    // Access decode: ret/popq address through valA, everything else through valE
    always_comb begin
        rd_s   = 1'b0;
        wr_s   = 1'b0;
        addr_s = m_r.valE;
        case (m_r.icode)
            4'h4:    wr_s = 1'b1;
            4'h5:    rd_s = 1'b1;
            4'h8:    wr_s = 1'b1;
            4'hA:    wr_s = 1'b1;
            4'h9: begin
                rd_s   = 1'b1;
                addr_s = m_r.valA;
            end
            4'hB: begin
                rd_s   = 1'b1;
                addr_s = m_r.valA;
            end
            default: begin
                rd_s = 1'b0;
                wr_s = 1'b0;
            end
        endcase
        addr_ok_s = (addr_s <= MAX_ADDR);
        base_s    = addr_ok_s ? addr_s[AW-1:0] : {AW{1'b0}};
    end

    // Little-endian 8-byte read; the base is clamped so the array is never indexed out of range
    always_comb begin
        rdata_s = 64'd0;
        for (int k = 0; k < 8; k++) begin
            rdata_s[8*k +: 8] = dmem_r[base_s + AW'(k)];
        end
    end

    // Status and read data after the access; an address error overrides the incoming status
    always_comb begin
        m_stat_s = m_r.stat;
        m_valm_s = 64'd0;
        if ((rd_s || wr_s) && !addr_ok_s) begin
            m_stat_s = STAT_ADR;
            m_valm_s = 64'd0;
        end else if (rd_s) begin
            m_stat_s = m_r.stat;
            m_valm_s = rdata_s;
        end else begin
            m_stat_s = m_r.stat;
            m_valm_s = 64'd0;
        end
        we_s = wr_s && addr_ok_s && (m_r.stat == STAT_AOK);
    end

    // Data memory write; a stalled M simply rewrites the same bytes
    always_ff @(posedge clk) begin
        if (we_s) begin
            for (int k = 0; k < 8; k++) begin
                dmem_r[base_s + AW'(k)] <= m_r.valA[8*k +: 8];
            end
        end
    end

    // M->W pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_r <= W_BUBBLE;
        end else if (!bus.W_stall) begin
            w_r <= '{stat: m_stat_s, icode: m_r.icode, valE: m_r.valE, valM: m_valm_s,
                     dstE: m_r.dstE, dstM: m_r.dstM};
        end else begin
            w_r <= w_r;
        end
    end

    assign bus.M_icode = m_r.icode;
    assign bus.M_cnd   = m_r.cnd;
    assign bus.M_valE  = m_r.valE;
    assign bus.M_dstE  = m_r.dstE;
    assign bus.M_dstM  = m_r.dstM;
    assign bus.m_valM  = m_valm_s;
    assign bus.m_stat  = m_stat_s;
    assign bus.W_stat  = w_r.stat;
    assign bus.W_icode = w_r.icode;
    assign bus.W_valE  = w_r.valE;
    assign bus.W_valM  = w_r.valM;
    assign bus.W_dstE  = w_r.dstE;
    assign bus.W_dstM  = w_r.dstM;
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios with literal expectations plus a randomized run,
// all outputs compared every cycle against a behavioural model of the stage.
module tb_memory_stage;
    localparam int DMEM = 1024;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } ins_t;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } wb_t;

    typedef struct packed {
        logic [3:0]  stat;
        logic [63:0] valM;
        logic        wr;
        logic [63:0] addr;
    } mres_t;

    localparam ins_t BUB_M = '{4'd1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF};
    localparam wb_t  BUB_W = '{4'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic chk_en = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    memory_stage_if bus ();

    memory_stage #(.DMEM_BYTES(DMEM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Behavioural model state
    ins_t       mdl_m;
    wb_t        mdl_w;
    logic [7:0] mdl_mem [DMEM];

    // What the instruction currently in M must produce, straight from the ISA rules
    function automatic mres_t mexp();
        mres_t       r;
        logic        is_rd;
        logic        is_wr;
        logic [63:0] a;
        is_rd = (mdl_m.icode == 4'h5) || (mdl_m.icode == 4'h9) || (mdl_m.icode == 4'hB);
        is_wr = (mdl_m.icode == 4'h4) || (mdl_m.icode == 4'h8) || (mdl_m.icode == 4'hA);
        a = ((mdl_m.icode == 4'h9) || (mdl_m.icode == 4'hB)) ? mdl_m.valA : mdl_m.valE;
        r.addr = a;
        r.valM = 64'd0;
        r.stat = mdl_m.stat;
        r.wr   = 1'b0;
        if ((is_rd || is_wr) && a > 64'(DMEM - 8)) begin
            r.stat = 4'd3;
        end else begin
            if (is_rd) begin
                for (int k = 0; k < 8; k++) r.valM = r.valM | (64'(mdl_mem[a + 64'(k)]) << (8 * k));
            end
            r.wr = is_wr && (mdl_m.stat == 4'd1);
        end
        return r;
    endfunction

    // Model clocking: mirrors the pipeline's observable contract
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_m <= BUB_M;
            mdl_w <= BUB_W;
        end else begin
            if (mexp().wr) begin
                for (int k = 0; k < 8; k++) mdl_mem[mexp().addr + 64'(k)] <= mdl_m.valA[8*k +: 8];
            end
            if (!bus.W_stall)
                mdl_w <= '{mexp().stat, mdl_m.icode, mdl_m.valE, mexp().valM, mdl_m.dstE, mdl_m.dstM};
            if (bus.M_bubble)
                mdl_m <= BUB_M;
            else if (!bus.M_stall)
                mdl_m <= '{bus.e_stat, bus.e_icode, bus.e_cnd, bus.e_valE, bus.e_valA, bus.e_dstE, bus.e_dstM};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("M_icode", 64'(bus.M_icode), 64'(mdl_m.icode));
            chk("M_cnd",   64'(bus.M_cnd),   64'(mdl_m.cnd));
            chk("M_valE",  bus.M_valE,       mdl_m.valE);
            chk("M_dstE",  64'(bus.M_dstE),  64'(mdl_m.dstE));
            chk("M_dstM",  64'(bus.M_dstM),  64'(mdl_m.dstM));
            chk("m_stat",  64'(bus.m_stat),  64'(mexp().stat));
            chk("m_valM",  bus.m_valM,       mexp().valM);
            chk("W_stat",  64'(bus.W_stat),  64'(mdl_w.stat));
            chk("W_icode", 64'(bus.W_icode), 64'(mdl_w.icode));
            chk("W_valE",  bus.W_valE,       mdl_w.valE);
            chk("W_valM",  bus.W_valM,       mdl_w.valM);
            chk("W_dstE",  64'(bus.W_dstE),  64'(mdl_w.dstE));
            chk("W_dstM",  64'(bus.W_dstM),  64'(mdl_w.dstM));
        end
    end

    task automatic drive(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                         input logic [3:0] de, input logic [3:0] dm, input logic [3:0] st = 4'd1,
                         input logic cnd = 1'b0);
        bus.e_icode = ic;
        bus.e_valE  = ve;
        bus.e_valA  = va;
        bus.e_dstE  = de;
        bus.e_dstM  = dm;
        bus.e_stat  = st;
        bus.e_cnd   = cnd;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_W_stat"},  64'(bus.W_stat),  64'd1);
        chk({tag, "_W_icode"}, 64'(bus.W_icode), 64'd1);
        chk({tag, "_W_valE"},  bus.W_valE,       64'd0);
        chk({tag, "_W_valM"},  bus.W_valM,       64'd0);
        chk({tag, "_W_dstE"},  64'(bus.W_dstE),  64'hF);
        chk({tag, "_W_dstM"},  64'(bus.W_dstM),  64'hF);
        chk({tag, "_M_icode"}, 64'(bus.M_icode), 64'd1);
        chk({tag, "_M_cnd"},   64'(bus.M_cnd),   64'd0);
        chk({tag, "_M_valE"},  bus.M_valE,       64'd0);
        chk({tag, "_M_dstE"},  64'(bus.M_dstE),  64'hF);
        chk({tag, "_M_dstM"},  64'(bus.M_dstM),  64'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] bad_addr [5];
        logic [63:0] a;
        logic [63:0] d;
        logic [3:0]  ic;
        logic [3:0]  st;
        bad_addr[0] = 64'(DMEM - 7);
        bad_addr[1] = 64'(DMEM);
        bad_addr[2] = -64'sd64;
        bad_addr[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        bad_addr[4] = 64'(DMEM - 8);

        drive(4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
        bus.M_stall = 1'b0;
        bus.M_bubble = 1'b0;
        bus.W_stall = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_bubble("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Preload the region used by reads so every read sees known bytes
        for (int i = 0; i <= 40; i++) begin
            drive(4'h4, 64'(8 * i), 64'h0102_0304_0506_0700 + 64'(i), 4'hF, 4'hF);
            cyc();
        end
        drive(4'h4, 64'(DMEM - 8), 64'hA5A5_0000_1234_5678, 4'hF, 4'hF);
        cyc();

        // rmmovq then mrmovq at 0x40
        drive(4'h4, 64'h40, 64'h1122_3344_5566_7788, 4'hF, 4'hF);
        cyc();
        drive(4'h5, 64'h40, 64'd0, 4'hF, 4'd3);
        cyc();
        chk("raw_m_valM", bus.m_valM, 64'h1122_3344_5566_7788);
        drive(4'h5, 64'h3F, 64'd0, 4'hF, 4'hF);
        cyc();
        chk("raw_W_valM", bus.W_valM, 64'h1122_3344_5566_7788);
        chk("raw_W_dstM", 64'(bus.W_dstM), 64'd3);
        chk("byte40", 64'(bus.m_valM[15:8]), 64'h88);

        // pushq / popq of a negative value
        drive(4'hA, 64'h100, -64'sd250, 4'h4, 4'hF);
        cyc();
        drive(4'hB, 64'h108, 64'h100, 4'h4, 4'h3);
        cyc();
        drive(4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
        cyc();
        chk("pop_W_valM", bus.W_valM, 64'hFFFF_FFFF_FFFF_FF06);
        chk("pop_W_stat", 64'(bus.W_stat), 64'd1);

        // Address errors at the boundary and with a negative address
        drive(4'h5, 64'(DMEM - 7), 64'd0, 4'hF, 4'd1);
        cyc();
        chk("adr_hi_stat", 64'(bus.m_stat), 64'd3);
        chk("adr_hi_valM", bus.m_valM, 64'd0);
        drive(4'h5, -64'sd64, 64'd0, 4'hF, 4'd1);
        cyc();
        chk("adr_neg_stat", 64'(bus.m_stat), 64'd3);
        chk("adr_neg_valM", bus.m_valM, 64'd0);
        drive(4'h4, 64'(DMEM), 64'hDEAD_BEEF_DEAD_BEEF, 4'hF, 4'hF);
        cyc();
        drive(4'h5, 64'(DMEM - 8), 64'd0, 4'hF, 4'd1);
        cyc();
        chk("adr_wr_W_stat", 64'(bus.W_stat), 64'd3);
        chk("adr_wr_last", bus.m_valM, 64'hA5A5_0000_1234_5678);
        drive(4'h5, 64'd0, 64'd0, 4'hF, 4'd1);
        cyc();
        chk("adr_wr_zero", bus.m_valM, 64'h0102_0304_0506_0700);

        // call held by M_stall, then read back; then stall+bubble
        drive(4'h8, 64'h80, 64'h1234, 4'h4, 4'hF);
        cyc();
        bus.M_stall = 1'b1;
        drive(4'h5, 64'h80, 64'd0, 4'hF, 4'd2);
        cyc();
        chk("stall1_icode", 64'(bus.M_icode), 64'h8);
        chk("stall1_valE", bus.M_valE, 64'h80);
        cyc();
        chk("stall2_icode", 64'(bus.M_icode), 64'h8);
        bus.M_stall = 1'b0;
        cyc();
        chk("call_rd", bus.m_valM, 64'h1234);
        bus.M_stall = 1'b1;
        bus.M_bubble = 1'b1;
        cyc();
        chk("sb_icode", 64'(bus.M_icode), 64'h1);
        chk("sb_dstE", 64'(bus.M_dstE), 64'hF);
        chk("sb_dstM", 64'(bus.M_dstM), 64'hF);
        bus.M_stall = 1'b0;
        bus.M_bubble = 1'b0;

        // W_stall holds W while a new instruction sits in M
        drive(4'h6, 64'h55, 64'd0, 4'h2, 4'hF);
        cyc();
        drive(4'h6, 64'h77, 64'd0, 4'h5, 4'hF);
        cyc();
        bus.W_stall = 1'b1;
        bus.M_stall = 1'b1;
        drive(4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
        cyc();
        chk("wst_valE", bus.W_valE, 64'h55);
        chk("wst_dstE", 64'(bus.W_dstE), 64'd2);
        bus.W_stall = 1'b0;
        cyc();
        chk("wrel_valE", bus.W_valE, 64'h77);
        chk("wrel_dstE", 64'(bus.W_dstE), 64'd5);
        bus.M_stall = 1'b0;

        // Halt status with a store: passes through, no write
        drive(4'h4, 64'h48, 64'hAAAA, 4'hF, 4'hF, 4'd2);
        cyc();
        drive(4'h5, 64'h48, 64'd0, 4'hF, 4'd1);
        cyc();
        chk("hlt_W_stat", 64'(bus.W_stat), 64'd2);
        chk("hlt_nowrite", bus.m_valM, 64'h0102_0304_0506_0709);

        // Randomized traffic with a mid-stream reset
        for (int n = 0; n < 500; n++) begin
            ic = 4'($urandom_range(0, 11));
            st = ($urandom_range(0, 15) == 0) ? (($urandom_range(0, 1) == 0) ? 4'd2 : 4'd4) : 4'd1;
            if (st != 4'd1 || $urandom_range(0, 9) != 0) a = 64'($urandom_range(0, 320));
            else a = bad_addr[$urandom_range(0, 4)];
            d = {$urandom, $urandom};
            if (ic == 4'h9 || ic == 4'hB) drive(ic, d, a, 4'($urandom), 4'($urandom), st, 1'($urandom));
            else drive(ic, a, d, 4'($urandom), 4'($urandom), st, 1'($urandom));
            bus.M_bubble = ($urandom_range(0, 9) == 0);
            bus.M_stall  = ($urandom_range(0, 4) == 0);
            bus.W_stall  = ($urandom_range(0, 5) == 0);
            cyc();
            if (n == 250) begin
                #2 rst_n = 1'b0;
                #1 chk_bubble("midrst");
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end
        bus.M_stall = 1'b0;
        bus.M_bubble = 1'b0;
        bus.W_stall = 1'b0;
        drive(4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
        cyc();
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
